// File: rtl/btn_conditioner.sv
// Five-button front end: 2-flop sync, per-bit debounce, press pulses and a held key event.
// Latency: btn_in -> btn_lvl/btn_pulse 2+DB_CYCLES cycles, btn_pulse -> key_valid 1 cycle.
// Backpressure: a new event while key_valid is unacknowledged is dropped and flagged on overrun.
// BTN_AUTOREPEAT_EN adds press repeats for the lowest-numbered held button.
module btn_conditioner #(
   parameter int N_BTN      = 5,
   parameter int DB_CYCLES  = 250000,
   parameter int CNT_W      = 18,
   parameter int REP_DELAY  = 25000000,
   parameter int REP_PERIOD = 5000000
) (
   input  logic             mclk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_in,
   input  logic             ack,
   output logic [N_BTN-1:0] btn_lvl,
   output logic [N_BTN-1:0] btn_pulse,
   output logic             key_valid,
   output logic [2:0]       key_code,
   output logic             overrun
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   if ((N_BTN < 1) || (N_BTN > 7) || (DB_CYCLES < 2) || (DB_CYCLES > (1 << CNT_W)) ||
       (REP_DELAY < 2) || (REP_PERIOD < 1)) begin : g_bad_cfg
      $error("btn_conditioner: unsupported parameter set");
   end

   logic [N_BTN-1:0] sync_q1;
   logic [N_BTN-1:0] sync_q2;
   logic [CNT_W-1:0] db_cnt [N_BTN];
   logic [N_BTN-1:0] lvl_nxt;
   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] pulse_nxt;
   logic [2:0]       pulse_code;
   logic [0:0]       state;

   // 1-based index of the lowest set bit, 0 when none is set
   function automatic logic [2:0] lowest_code(input logic [N_BTN-1:0] v);
      lowest_code = 3'd0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (v[i]) lowest_code = 3'(i + 1);
      end
   endfunction

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= btn_in;
         sync_q2 <= sync_q1;
      end
   end

   always_comb begin
      lvl_nxt = btn_lvl;
      rise    = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (sync_q2[i] != btn_lvl[i] && db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
            lvl_nxt[i] = sync_q2[i];
            rise[i]    = sync_q2[i];
         end
      end
   end

   // The clear at DB_CYCLES-1 keeps the counter from ever wrapping
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
         btn_lvl   <= '0;
         btn_pulse <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (sync_q2[i] == btn_lvl[i] || db_cnt[i] == CNT_W'(DB_CYCLES - 1))
               db_cnt[i] <= '0;
            else
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
         end
         btn_lvl   <= lvl_nxt;
         btn_pulse <= pulse_nxt;
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep_cnt;
   logic [2:0]       rep_code;
   logic [2:0]       hold_code;
   logic             rep_first;
   logic             rep_track;
   logic             rep_fire;
   logic [N_BTN-1:0] rep_mask;

   // rep_cnt counts cycles since the last pulse of the tracked button
   always_comb begin
      hold_code = lowest_code(btn_lvl);
      rep_track = (hold_code != 3'd0) && (hold_code == rep_code);
      rep_fire  = 1'b0;
      rep_mask  = '0;
      if (rep_track)
         rep_fire = rep_first ? (rep_cnt == REP_W'(REP_DELAY - 1))
                              : (rep_cnt == REP_W'(REP_PERIOD - 1));
      for (int i = 0; i < N_BTN; i++) begin
         if (hold_code == 3'(i + 1)) rep_mask[i] = rep_fire;
      end
      pulse_nxt = rise | (rep_mask & lvl_nxt);
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt   <= '0;
         rep_code  <= 3'd0;
         rep_first <= 1'b1;
      end else if (rep_track) begin
         if (rep_fire) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
         end
      end else begin
         rep_code  <= hold_code;
         rep_cnt   <= REP_W'(1);
         rep_first <= 1'b1;
      end
   end
`else
   assign pulse_nxt = rise;
`endif

   assign pulse_code = lowest_code(btn_pulse);

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         key_valid <= 1'b0;
         key_code  <= 3'd0;
         overrun   <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (btn_pulse != '0) begin
            key_code  <= pulse_code;
            key_valid <= 1'b1;
            state     <= ST_HOLD;
         end
      end else begin
         if (ack) begin
            overrun <= 1'b0;
            if (btn_pulse != '0) begin
               key_code <= pulse_code;
            end else begin
               key_valid <= 1'b0;
               key_code  <= 3'd0;
               state     <= ST_IDLE;
            end
         end else if (btn_pulse != '0) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with DB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3.
module tb_btn_conditioner;

   logic       mclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ack = 1'b0;
   logic [4:0] btn_in = 5'h1F;
   logic [4:0] btn_lvl;
   logic [4:0] btn_pulse;
   logic       key_valid;
   logic [2:0] key_code;
   logic       overrun;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [2:0] exp_q[$];
   logic [2:0] mon_exp;
   logic       kv_q = 1'b0;

   typedef struct {
      logic [4:0] btn;
      int         hold;
      logic [4:0] exp_lvl;
      logic [2:0] exp_code;
   } vec_t;

   vec_t vecs[8];
   vec_t v;

   btn_conditioner #(
      .N_BTN(5), .DB_CYCLES(4), .CNT_W(3), .REP_DELAY(10), .REP_PERIOD(3)
   ) dut (
      .mclk(mclk), .rst_n(rst_n), .btn_in(btn_in), .ack(ack),
      .btn_lvl(btn_lvl), .btn_pulse(btn_pulse), .key_valid(key_valid),
      .key_code(key_code), .overrun(overrun)
   );

   always #5 mclk = ~mclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   task automatic release_all();
      btn_in = 5'h00;
      repeat (14) step();
   endtask

   function automatic bit rep_exp(int k);
`ifdef BTN_AUTOREPEAT_EN
      return (k == 6) || (k >= 16 && k <= 40 && ((k - 16) % 3) == 0);
`else
      return (k == 6);
`endif
   endfunction

   // Scoreboard: each new key event must match the oldest expected code
   always @(negedge mclk) begin
      if (!rst_n) begin
         kv_q = 1'b0;
      end else begin
         if (key_valid && !kv_q) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_event: got code %0d, required no event", key_code);
            end else begin
               mon_exp = exp_q.pop_front();
               check("sb_code", 32'(key_code), 32'(mon_exp));
            end
         end
         kv_q = key_valid;
      end
   end

   initial begin
      vecs[0] = '{5'b00100, 3, 5'b00000, 3'd0};
      vecs[1] = '{5'b00100, 4, 5'b00100, 3'd3};
      vecs[2] = '{5'b01000, 8, 5'b01000, 3'd4};
      vecs[3] = '{5'b10010, 8, 5'b10010, 3'd2};
      vecs[4] = '{5'b00001, 6, 5'b00001, 3'd1};
      vecs[5] = '{5'b10000, 7, 5'b10000, 3'd5};
      vecs[6] = '{5'b11000, 5, 5'b11000, 3'd4};
      vecs[7] = '{5'b00100, 2, 5'b00000, 3'd0};

      // Reset with all buttons pressed
      #22;
      check("rst_lvl", 32'(btn_lvl), 32'h0);
      check("rst_pulse", 32'(btn_pulse), 32'h0);
      check("rst_valid", 32'(key_valid), 32'h0);
      check("rst_code", 32'(key_code), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      @(negedge mclk);
      rst_n = 1'b1;
      exp_q.push_back(3'd1);
      repeat (5) step();
      check("rst_lvl_early", 32'(btn_lvl), 32'h0);
      step();
      check("rst_lvl_6", 32'(btn_lvl), 32'h1F);
      check("rst_pulse_6", 32'(btn_pulse), 32'h1F);
      step();
      check("rst_valid_7", 32'(key_valid), 32'h1);
      check("rst_code_7", 32'(key_code), 32'h1);
      check("rst_overrun_7", 32'(overrun), 32'h0);
      check("rst_pulse_7", 32'(btn_pulse), 32'h0);
      do_ack();
      check("rst_ack_valid", 32'(key_valid), 32'h0);
      check("rst_ack_code", 32'(key_code), 32'h0);
      release_all();
      check("rel_lvl", 32'(btn_lvl), 32'h0);
      check("rel_valid", 32'(key_valid), 32'h0);

      // Ack while idle does nothing
      do_ack();
      check("idle_ack_valid", 32'(key_valid), 32'h0);
      check("idle_ack_code", 32'(key_code), 32'h0);

      for (int n = 0; n < 8; n++) begin
         v = vecs[n];
         if (v.exp_code != 3'd0) exp_q.push_back(v.exp_code);
         btn_in = v.btn;
         for (int k = 1; k <= 14; k++) begin
            step();
            if (k == v.hold) btn_in = 5'h00;
            if (k == 6) begin
               check($sformatf("vec%0d_lvl", n), 32'(btn_lvl), 32'(v.exp_lvl));
               check($sformatf("vec%0d_pulse", n), 32'(btn_pulse), 32'(v.exp_lvl));
            end
            if (k == 7) check($sformatf("vec%0d_pulse_off", n), 32'(btn_pulse), 32'h0);
         end
         check($sformatf("vec%0d_lvl_rel", n), 32'(btn_lvl), 32'h0);
         check($sformatf("vec%0d_valid", n), 32'(key_valid), 32'(v.exp_code != 3'd0));
         check($sformatf("vec%0d_code", n), 32'(key_code), 32'(v.exp_code));
         check($sformatf("vec%0d_overrun", n), 32'(overrun), 32'h0);
         if (v.exp_code != 3'd0) do_ack();
      end

      // Press while holding an event sets overrun; ack clears it
      exp_q.push_back(3'd2);
      btn_in = 5'b10010;
      repeat (8) step();
      check("ovr_code_first", 32'(key_code), 32'h2);
      check("ovr_flag_first", 32'(overrun), 32'h0);
      btn_in = 5'b10011;
      repeat (8) step();
      check("ovr_flag", 32'(overrun), 32'h1);
      check("ovr_code_kept", 32'(key_code), 32'h2);
      check("ovr_valid", 32'(key_valid), 32'h1);
      do_ack();
      check("ovr_cleared", 32'(overrun), 32'h0);
      check("ovr_ack_valid", 32'(key_valid), 32'h0);
      release_all();

      // Ack coinciding with a new press captures it and stays valid
      exp_q.push_back(3'd2);
      btn_in = 5'b00010;
      repeat (4) step();
      btn_in = 5'b00000;
      repeat (4) step();
      check("coin_code_first", 32'(key_code), 32'h2);
      btn_in = 5'b10000;
      repeat (6) step();
      check("coin_pulse4", 32'(btn_pulse), 32'h10);
      do_ack();
      check("coin_valid", 32'(key_valid), 32'h1);
      check("coin_code", 32'(key_code), 32'h5);
      check("coin_overrun", 32'(overrun), 32'h0);
      do_ack();
      check("coin_ack_valid", 32'(key_valid), 32'h0);
      release_all();

      // Reset during HOLD loses the event; a held button re-presses afterwards
      exp_q.push_back(3'd1);
      btn_in = 5'b00001;
      repeat (8) step();
      rst_n = 1'b0;
      #2;
      check("mid_rst_valid", 32'(key_valid), 32'h0);
      check("mid_rst_lvl", 32'(btn_lvl), 32'h0);
      check("mid_rst_code", 32'(key_code), 32'h0);
      @(negedge mclk);
      rst_n = 1'b1;
      exp_q.push_back(3'd1);
      repeat (5) step();
      check("mid_rst_lvl_early", 32'(btn_lvl), 32'h0);
      step();
      check("mid_rst_lvl_6", 32'(btn_lvl), 32'h01);
      step();
      check("mid_rst_valid_7", 32'(key_valid), 32'h1);
      do_ack();
      release_all();

      // Hold button 1, acking every event; repeats only with autorepeat built
      btn_in = 5'b00010;
      for (int k = 1; k <= 50; k++) begin
         step();
         if (k == 36) btn_in = 5'b00000;
         if (rep_exp(k)) begin
            exp_q.push_back(3'd2);
            check($sformatf("rep_pulse_k%0d", k), 32'(btn_pulse), 32'h02);
         end else begin
            check($sformatf("rep_pulse_k%0d", k), 32'(btn_pulse), 32'h00);
         end
         ack = key_valid;
      end
      ack = 1'b0;
      check("rep_overrun", 32'(overrun), 32'h0);
      check("rep_valid_end", 32'(key_valid), 32'h0);
      step();
      check("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
